// File: rtl/mult_div_unit.sv
// Iterative MULT/MULTU/DIV/DIVU engine that owns the architectural HI/LO registers.
// Latency: done pulses WIDTH+1 edges after the start edge, or 1 edge for a divide by zero.
// Backpressure: none; start and MTHI/MTLO writes are accepted only while idle, otherwise dropped.
module mult_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);

  localparam int CW = $clog2(WIDTH + 1);

  // op encoding: bit1 selects divide, bit0 selects unsigned
  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    FIX  = 2'd2
  } state_t;

  state_t             r_state;
  state_t             w_state_nxt;

  // Latched operation context
  logic [1:0]         r_op;
  logic [WIDTH-1:0]   r_opb;      // multiplicand (mul) or divisor (div) magnitude
  logic [2*WIDTH-1:0] r_acc;      // mul: {partial product, multiplier}; div: low half is dividend/quotient
  logic [WIDTH:0]     r_rem;      // partial remainder for restoring division
  logic [CW-1:0]      r_cnt;
  logic               r_neg_q;    // negate product / quotient
  logic               r_neg_r;    // negate remainder (follows dividend sign)
  logic               r_dbz;      // divide by zero detected at start

  // Architectural state and registered pulses
  logic [WIDTH-1:0]   r_hi;
  logic [WIDTH-1:0]   r_lo;
  logic               r_done;
  logic               r_dbz_pulse;

  // Operand conditioning
  logic               w_signed;
  logic               w_a_neg;
  logic               w_b_neg;
  logic [WIDTH-1:0]   w_a_mag;
  logic [WIDTH-1:0]   w_b_mag;
  logic               w_b_zero;
  logic               w_is_div_in;

  // Iteration datapath
  logic [WIDTH:0]     w_mul_sum;
  logic [2*WIDTH-1:0] w_mul_nxt;
  logic [WIDTH:0]     w_shift;
  logic [WIDTH+1:0]   w_diff;
  logic               w_qbit;
  logic [WIDTH:0]     w_rem_nxt;
  logic [2*WIDTH-1:0] w_div_nxt;

  // Sign fix-up results
  logic [2*WIDTH-1:0] w_prod;
  logic [WIDTH-1:0]   w_quo;
  logic [WIDTH-1:0]   w_rmd;

  // Control decode
  logic               w_last;
  logic               w_done_nxt;
  logic               w_dbz_nxt;

  // Magnitudes and sign flags of the incoming operands
  always_comb begin
    w_signed    = (op == OP_MULT) || (op == OP_DIV);
    w_is_div_in = (op == OP_DIV) || (op == OP_DIVU);
    w_a_neg     = w_signed & a[WIDTH-1];
    w_b_neg     = w_signed & b[WIDTH-1];
    w_a_mag     = w_a_neg ? (~a + 1'b1) : a;
    w_b_mag     = w_b_neg ? (~b + 1'b1) : b;
    w_b_zero    = (b == '0);
  end

  // One multiply step (shift-add) and one restoring-divide step
  always_comb begin
    w_mul_sum = {1'b0, r_acc[2*WIDTH-1:WIDTH]} + (r_acc[0] ? {1'b0, r_opb} : {(WIDTH+1){1'b0}});
    w_mul_nxt = {w_mul_sum, r_acc[WIDTH-1:1]};
    w_shift   = {r_rem[WIDTH-1:0], r_acc[WIDTH-1]};
    w_diff    = {1'b0, w_shift} - {2'b00, r_opb};
    w_qbit    = ~w_diff[WIDTH+1];
    w_rem_nxt = w_qbit ? w_diff[WIDTH:0] : w_shift;
    w_div_nxt = {r_acc[2*WIDTH-1:WIDTH], r_acc[WIDTH-2:0], w_qbit};
  end

  // Final sign correction applied in FIX
  always_comb begin
    w_prod = r_neg_q ? (~r_acc + 1'b1) : r_acc;
    w_quo  = r_neg_q ? (~r_acc[WIDTH-1:0] + 1'b1) : r_acc[WIDTH-1:0];
    w_rmd  = r_neg_r ? (~r_rem[WIDTH-1:0] + 1'b1) : r_rem[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state and next-pulse decode
  always_comb begin
    w_state_nxt = r_state;
    w_last      = (r_cnt == CW'(WIDTH - 1));
    w_done_nxt  = 1'b0;
    w_dbz_nxt   = 1'b0;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (w_is_div_in && w_b_zero) ? FIX : CALC;
        end
      end
      CALC: begin
        if (w_last) begin
          w_state_nxt = FIX;
        end
      end
      FIX: begin
        w_state_nxt = IDLE;
        w_done_nxt  = 1'b1;
        w_dbz_nxt   = r_dbz;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  // Operation context, iteration registers, HI/LO and output pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      r_op        <= OP_MULT;
      r_opb       <= '0;
      r_acc       <= '0;
      r_rem       <= '0;
      r_cnt       <= '0;
      r_neg_q     <= 1'b0;
      r_neg_r     <= 1'b0;
      r_dbz       <= 1'b0;
      r_hi        <= '0;
      r_lo        <= '0;
      r_done      <= 1'b0;
      r_dbz_pulse <= 1'b0;
    end else begin
      r_done      <= w_done_nxt;
      r_dbz_pulse <= w_dbz_nxt;
      case (r_state)
        IDLE: begin
          if (hi_we) begin
            r_hi <= wdata;
          end
          if (lo_we) begin
            r_lo <= wdata;
          end
          if (start) begin
            r_op    <= op;
            r_opb   <= w_b_mag;
            r_acc   <= {{WIDTH{1'b0}}, w_a_mag};
            r_rem   <= '0;
            r_cnt   <= '0;
            r_neg_q <= w_a_neg ^ w_b_neg;
            r_neg_r <= w_a_neg;
            r_dbz   <= w_is_div_in & w_b_zero;
          end
        end
        CALC: begin
          r_cnt <= r_cnt + CW'(1);
          if (r_op[1]) begin
            r_acc <= w_div_nxt;
            r_rem <= w_rem_nxt;
          end else begin
            r_acc <= w_mul_nxt;
          end
        end
        FIX: begin
          // A divide by zero leaves HI/LO untouched
          if (!r_dbz) begin
            if (r_op[1]) begin
              r_hi <= w_rmd;
              r_lo <= w_quo;
            end else begin
              r_hi <= w_prod[2*WIDTH-1:WIDTH];
              r_lo <= w_prod[WIDTH-1:0];
            end
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy        = (r_state != IDLE);
  assign done        = r_done;
  assign div_by_zero = r_dbz_pulse;
  assign hi          = r_hi;
  assign lo          = r_lo;

endmodule
